dds_addr_gen: RTL and testbench

- Direct-digital-synthesis front end that drives the sine look-up ROM.
- Holds a phase accumulator stepped by a programmable frequency tuning word (FTW) and adds a phase offset.
- Presents the accumulator MSBs as the ROM address, then captures the ROM's registered-address read data into an aligned, valid-qualified sample stream.
- Sits between the control/register interface and the DAC/sample consumer. The sine ROM is instantiated beside it, not inside it.

---
 rtl/dds_addr_gen.sv | 73 +++++++
 tb/tb_dds_addr_gen.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/dds_addr_gen.sv
// dds_addr_gen: DDS phase accumulator that addresses a sine ROM and returns an aligned sample stream
// Ports: clk, rst_n (async active-low reset); en advances the phase and launches one ROM read;
//   ftw_wr/ftw load the frequency tuning word; pofs is the phase offset added to the address;
//   rom_ce_n/rom_addr drive the external ROM; rom_data is its read data one cycle later;
//   dout/dout_vld carry the captured sample; wrap pulses on accumulator overflow.
module dds_addr_gen #(
  parameter int AW = 8,
  parameter int DW = 16,
  parameter int PW = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          ftw_wr,
  input  logic [PW-1:0] ftw,
  input  logic [AW-1:0] pofs,
  output logic          rom_ce_n,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  output logic          wrap
);
  logic [PW-1:0] acc_q, acc_d, ftw_act_q, ftw_act_d, ftw_pend_q, ftw_pend_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          pend_q, pend_d, v1_q, v2_q, vld_q, wrap_q;
  logic [PW:0]   sum;
  logic          carry, apply;
  // A pending tuning word may only land where it keeps the phase continuous:
  // on a carry edge, or on any edge where the accumulator is idle.
  always_comb begin
    sum        = {1'b0, acc_q} + {1'b0, ftw_act_q};
    carry      = en & sum[PW];
    apply      = carry | ~en;
    acc_d      = en ? sum[PW-1:0] : acc_q;
    ftw_act_d  = (ftw_wr & apply) ? ftw : (pend_q & apply) ? ftw_pend_q : ftw_act_q;
    ftw_pend_d = (ftw_wr & ~apply) ? ftw : ftw_pend_q;
    pend_d     = ftw_wr ? ~apply : pend_q & ~apply;
    addr_d     = en ? acc_q[PW-1:PW-AW] + pofs : addr_q;
    dout_d     = v2_q ? rom_data : dout_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      ftw_act_q  <= '0;
      ftw_pend_q <= '0;
      pend_q     <= 1'b0;
      addr_q     <= '0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      dout_q     <= '0;
      vld_q      <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      ftw_act_q  <= ftw_act_d;
      ftw_pend_q <= ftw_pend_d;
      pend_q     <= pend_d;
      addr_q     <= addr_d;
      v1_q       <= en;
      v2_q       <= v1_q;
      dout_q     <= dout_d;
      vld_q      <= v2_q;
      wrap_q     <= carry;
    end
  end
  assign rom_ce_n = ~v1_q;
  assign rom_addr = addr_q;
  assign dout     = dout_q;
  assign dout_vld = vld_q;
  assign wrap     = wrap_q;
endmodule

// File: tb/tb_dds_addr_gen.sv
// tb_dds_addr_gen: table-driven and scoreboard checks of the DDS address generator
module tb_dds_addr_gen;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int PW = 24;
  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0;
  logic          ftw_wr = 1'b0;
  logic [PW-1:0] ftw = '0;
  logic [AW-1:0] pofs = '0;
  logic          rom_ce_n;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data = '0;
  logic [DW-1:0] dout;
  logic          dout_vld;
  logic          wrap;
  int            tests = 0;
  int            fails = 0;
  int            nwrap = 0;
  logic          e1 = 1'b0;
  logic          e2 = 1'b0;
  logic [DW-1:0] q[$];
  typedef struct {
    logic [PW-1:0] ftw;
    logic [AW-1:0] pofs;
    int            n;
    int            wraps;
    logic [AW-1:0] last;
  } vec_t;
  vec_t tbl[5];
  always #5 clk = ~clk;
  dds_addr_gen #(.AW(AW), .DW(DW), .PW(PW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ftw_wr(ftw_wr), .ftw(ftw), .pofs(pofs),
    .rom_ce_n(rom_ce_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .dout(dout), .dout_vld(dout_vld), .wrap(wrap)
  );
  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    return {a, ~a} ^ 16'h5A3C;
  endfunction
  always @(posedge clk) rom_data <= rom_f(rom_addr);
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && dout_vld) begin
      check("sample_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) check("dout", 32'(dout), 32'(q.pop_front()));
    end
  end
  task automatic cyc(input logic e, input logic wr, input logic [PW-1:0] w,
                     input logic [AW-1:0] ea, input logic ew);
    en = e;
    ftw_wr = wr;
    if (wr) ftw = w;
    @(posedge clk);
    #1;
    ftw_wr = 1'b0;
    check("rom_addr", 32'(rom_addr), 32'(ea));
    check("rom_ce_n", 32'(rom_ce_n), 32'(!e));
    check("wrap", 32'(wrap), 32'(ew));
    check("dout_vld", 32'(dout_vld), 32'(e2));
    e2 = e1;
    e1 = e;
    if (e) q.push_back(rom_f(ea));
    if (wrap) nwrap++;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    ftw_wr = 1'b0;
    q.delete();
    #1;
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_rom_ce_n", 32'(rom_ce_n), 32'd1);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_dout_vld", 32'(dout_vld), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    e1 = 1'b0;
    e2 = 1'b0;
    nwrap = 0;
  endtask
  task automatic drain(input logic [AW-1:0] last);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, last, 1'b0);
    check("drained", 32'(q.size()), 32'd0);
  endtask
  initial begin
    logic [63:0] a0, a1;
    logic [AW-1:0] ea;
    tbl[0] = '{24'h010000, 8'h00, 8,   0, 8'h07};
    tbl[1] = '{24'h010000, 8'h00, 260, 1, 8'h03};
    tbl[2] = '{24'h400000, 8'h40, 12,  3, 8'h00};
    tbl[3] = '{24'h000000, 8'h33, 10,  0, 8'h33};
    tbl[4] = '{24'hFFFFFF, 8'h00, 6,   5, 8'hFF};
    #3;
    foreach (tbl[t]) begin
      do_reset();
      pofs = tbl[t].pofs;
      cyc(1'b0, 1'b1, tbl[t].ftw, '0, 1'b0);
      for (int i = 1; i <= tbl[t].n; i++) begin
        a0 = 64'(i - 1) * 64'(tbl[t].ftw);
        a1 = 64'(i) * 64'(tbl[t].ftw);
        ea = a0[PW-1:PW-AW] + tbl[t].pofs;
        cyc(1'b1, 1'b0, '0, ea, (a1 >> PW) != (a0 >> PW));
      end
      check("wrap_count", 32'(nwrap), 32'(tbl[t].wraps));
      check("last_addr", 32'(rom_addr), 32'(tbl[t].last));
      drain(tbl[t].last);
    end
    // phase-continuous change: pending word overwritten, applied on the carry edge
    do_reset();
    pofs = '0;
    cyc(1'b0, 1'b1, 24'h010000, '0, 1'b0);
    for (int i = 1; i <= 262; i++) begin
      ea = (i <= 256) ? 8'(i - 1) : 8'((i - 257) * 2);
      cyc(1'b1, i == 102 || i == 150, (i == 102) ? 24'h030000 : 24'h020000, ea, i == 256);
    end
    check("chg_wraps", 32'(nwrap), 32'd1);
    drain(8'd10);
    // ftw_wr on the carry edge bypasses the pending register
    do_reset();
    cyc(1'b0, 1'b1, 24'h400000, '0, 1'b0);
    cyc(1'b1, 1'b0, '0, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, '0, 8'h40, 1'b0);
    cyc(1'b1, 1'b0, '0, 8'h80, 1'b0);
    cyc(1'b1, 1'b1, 24'h100000, 8'hC0, 1'b1);
    cyc(1'b1, 1'b0, '0, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, '0, 8'h10, 1'b0);
    cyc(1'b1, 1'b0, '0, 8'h20, 1'b0);
    cyc(1'b1, 1'b0, '0, 8'h30, 1'b0);
    drain(8'h30);
    // pending word applied when en falls
    do_reset();
    cyc(1'b0, 1'b1, 24'h010000, '0, 1'b0);
    cyc(1'b1, 1'b0, '0, 8'd0, 1'b0);
    cyc(1'b1, 1'b0, '0, 8'd1, 1'b0);
    cyc(1'b1, 1'b0, '0, 8'd2, 1'b0);
    cyc(1'b1, 1'b1, 24'h040000, 8'd3, 1'b0);
    cyc(1'b0, 1'b0, '0, 8'd3, 1'b0);
    cyc(1'b1, 1'b0, '0, 8'd4, 1'b0);
    cyc(1'b1, 1'b0, '0, 8'd8, 1'b0);
    cyc(1'b1, 1'b0, '0, 8'd12, 1'b0);
    drain(8'd12);
    // bubbles: hold address, vld gap two edges later, resume without skipping
    do_reset();
    cyc(1'b0, 1'b1, 24'h010000, '0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, '0, 8'(i), 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, '0, 8'd9, 1'b0);
    for (int i = 10; i < 15; i++) cyc(1'b1, 1'b0, '0, 8'(i), 1'b0);
    drain(8'd14);
    // asynchronous reset mid-run, then restart at pofs with a cleared tuning word
    do_reset();
    pofs = 8'h21;
    cyc(1'b0, 1'b1, 24'h010000, '0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, '0, 8'(8'h21 + i), 1'b0);
    #2;
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, '0, 8'h21, 1'b0);
    check("zero_ftw_wraps", 32'(nwrap), 32'd0);
    drain(8'h21);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
